// File: rtl/uart_rx_if.sv
// uart_rx_if: tick/serial input and received-word outputs of the UART receiver
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 Tick;
    logic                 Rx;
    logic [DATA_BITS-1:0] RxData;
    logic                 RxDone;
    logic                 FrameErr;
    logic                 Busy;
    modport master (output Tick, Rx, input RxData, RxDone, FrameErr, Busy);
    modport slave  (input Tick, Rx, output RxData, RxDone, FrameErr, Busy);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver, 1 start / DATA_BITS data (LSB first) / 1 stop, no parity
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input logic     Clk,
    input logic     Rst_n,
    uart_rx_if.slave bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_meta_d, rx_s_q, rx_s_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic                 done_q, done_d, ferr_q, ferr_d, busy_q, busy_d;

    // next-state and output logic; every counter decision is taken only on a Tick
    always_comb begin
        rx_meta_d = bus.Rx;
        rx_s_d    = rx_meta_q;
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        data_d    = data_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            IDLE: if (!rx_s_q) begin
                state_d = START;
                tick_d  = '0;
            end
            START: if (bus.Tick) begin
                if (tick_q == HALF) begin
                    state_d = rx_s_q ? IDLE : DATA;
                    tick_d  = '0;
                    bit_d   = '0;
                end else tick_d = tick_q + TW'(1);
            end
            DATA: if (bus.Tick) begin
                if (tick_q == LAST) begin
                    shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    tick_d  = '0;
                    bit_d   = bit_q + BW'(1);
                    state_d = (bit_q == BLAST) ? STOP : DATA;
                end else tick_d = tick_q + TW'(1);
            end
            STOP: if (bus.Tick) begin
                if (tick_q == LAST) begin
                    tick_d  = '0;
                    state_d = rx_s_q ? IDLE : BREAK;
                    data_d  = rx_s_q ? shift_q : data_q;
                    done_d  = rx_s_q;
                    ferr_d  = !rx_s_q;
                end else tick_d = tick_q + TW'(1);
            end
            BREAK: if (rx_s_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // state, synchronizer and registered outputs; reset aborts any frame silently
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q   <= IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= rx_meta_d;
            rx_s_q    <= rx_s_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.RxData   = data_q;
    assign bus.RxDone   = done_q;
    assign bus.FrameErr = ferr_q;
    assign bus.Busy     = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames with a byte scoreboard checked on every RxDone
module tb_uart_rx;
    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    logic tick_en = 1'b1;
    int   tick_div = 0;
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   ferr_cnt = 0;
    logic [7:0] exp_q[$];

    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus));

    always #5 Clk = ~Clk;

    // baud tick: one pulse every 4 clocks, driven away from the active edge
    always @(negedge Clk) begin
        tick_div = (tick_div == 3) ? 0 : tick_div + 1;
        bus.Tick = tick_en && (tick_div == 3);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: each RxDone cycle pops one expected byte
    always @(negedge Clk) begin
        if (bus.RxDone) begin
            done_cnt++;
            chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) chk("rxdata", 32'(bus.RxData), 32'(exp_q.pop_front()));
        end
        if (bus.FrameErr) ferr_cnt++;
        if (bus.RxDone || bus.FrameErr) chk("done_ferr_excl", 32'(bus.RxDone && bus.FrameErr), 0);
    end

    // one frame; data/stop edges displaced alternately by +skew / -skew clocks
    task automatic send_frame(input logic [7:0] b, input logic stop, input int skew);
        int off[11];
        logic v;
        for (int k = 0; k < 11; k++) off[k] = (k >= 1 && k <= 9) ? ((k % 2) ? skew : -skew) : 0;
        for (int k = 0; k < 10; k++) begin
            v = (k == 0) ? 1'b0 : (k == 9) ? stop : b[k-1];
            bus.Rx = v;
            repeat (64 + off[k+1] - off[k]) @(negedge Clk);
        end
    endtask

    initial begin
        bus.Rx = 1'b1;
        bus.Tick = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_rxdata", 32'(bus.RxData), 0);
        chk("rst_rxdone", 32'(bus.RxDone), 0);
        chk("rst_ferr", 32'(bus.FrameErr), 0);
        chk("rst_busy", 32'(bus.Busy), 0);
        Rst_n = 1'b1;
        repeat (20) @(negedge Clk);

        // back-to-back frames
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hA5);
        send_frame(8'h55, 1'b1, 0);
        send_frame(8'hA5, 1'b1, 0);
        repeat (64) @(negedge Clk);
        chk("t1_done_cnt", 32'(done_cnt), 2);
        chk("t1_ferr_cnt", 32'(ferr_cnt), 0);
        chk("t1_sb_drained", 32'(exp_q.size()), 0);
        chk("t1_rxdata", 32'(bus.RxData), 32'hA5);

        // short low glitch is rejected at mid start bit
        bus.Rx = 1'b0;
        repeat (12) @(negedge Clk);
        chk("t2_busy_glitch", 32'(bus.Busy), 1);
        bus.Rx = 1'b1;
        repeat (64) @(negedge Clk);
        chk("t2_busy_idle", 32'(bus.Busy), 0);
        chk("t2_done_cnt", 32'(done_cnt), 2);
        chk("t2_ferr_cnt", 32'(ferr_cnt), 0);

        // bad stop bit, line held low: framing error then break until line high
        send_frame(8'h3C, 1'b0, 0);
        repeat (4 * 64) @(negedge Clk);
        chk("t3_ferr_cnt", 32'(ferr_cnt), 1);
        chk("t3_done_cnt", 32'(done_cnt), 2);
        chk("t3_rxdata_kept", 32'(bus.RxData), 32'hA5);
        chk("t3_busy_break", 32'(bus.Busy), 1);
        bus.Rx = 1'b1;
        repeat (8) @(negedge Clk);
        chk("t3_busy_idle", 32'(bus.Busy), 0);
        repeat (64) @(negedge Clk);

        // reset in the middle of data bit 4 of 0xFF
        bus.Rx = 1'b0;
        repeat (64) @(negedge Clk);
        bus.Rx = 1'b1;
        repeat (4 * 64 + 32) @(negedge Clk);
        chk("t4_busy_pre", 32'(bus.Busy), 1);
        Rst_n = 1'b0;
        @(negedge Clk);
        chk("t4_rst_rxdata", 32'(bus.RxData), 0);
        chk("t4_rst_busy", 32'(bus.Busy), 0);
        chk("t4_rst_done", 32'(bus.RxDone), 0);
        chk("t4_rst_ferr", 32'(bus.FrameErr), 0);
        Rst_n = 1'b1;
        repeat (5 * 64) @(negedge Clk);
        chk("t4_no_flags", 32'(done_cnt + ferr_cnt), 3);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 0);
        repeat (32) @(negedge Clk);
        chk("t4_done_cnt", 32'(done_cnt), 3);
        chk("t4_rxdata", 32'(bus.RxData), 32'h81);

        // edge skew margin
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, 5);
        send_frame(8'hC3, 1'b1, -5);
        repeat (32) @(negedge Clk);
        chk("t5_done_cnt", 32'(done_cnt), 5);
        chk("t5_ferr_cnt", 32'(ferr_cnt), 1);
        chk("t5_sb_drained", 32'(exp_q.size()), 0);

        // no ticks: FSM parks in START
        tick_en = 1'b0;
        bus.Rx = 1'b0;
        repeat (100) @(negedge Clk);
        chk("t6_busy_start", 32'(bus.Busy), 1);
        bus.Rx = 1'b1;
        repeat (8) @(negedge Clk);
        chk("t6_busy_hold", 32'(bus.Busy), 1);
        chk("t6_rxdata", 32'(bus.RxData), 32'hC3);
        tick_en = 1'b1;
        repeat (64) @(negedge Clk);
        chk("t6_busy_idle", 32'(bus.Busy), 0);
        chk("t6_flags", 32'(done_cnt + ferr_cnt), 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
